// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target
// Brief    : 7-bit-address I2C target with oversampled SCL/SDA, open-drain SDA,
//            no clock stretching. Optional general-call ACK: I2C_TARGET_GENCALL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_target #(
  parameter logic [6:0] ADDRESS     = 7'h27,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       SCL,
  input  logic       SDAIn,
  output logic       SDAPullLow,
  input  logic [7:0] TxData,
  output logic       TxLoad,
  output logic [7:0] RxData,
  output logic       RxValid,
  output logic       Addressed,
  output logic       Busy
);

  localparam logic [3:0] c_LAST_BIT = 4'd7;
  localparam logic [3:0] c_BYTE_END = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_WRITE     = 3'd3,
    S_WRITE_ACK = 3'd4,
    S_READ      = 3'd5,
    S_READ_ACK  = 3'd6,
    S_IGNORE    = 3'd7
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_bitcnt, w_bitcnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [7:0] r_txshift, w_txshift_nxt;
  logic [7:0] r_rxdata, w_rxdata_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_phase, w_phase_nxt;
  logic       r_sda_low, w_sda_low_nxt;
  logic       r_addressed, w_addressed_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_rxvalid, w_rxvalid_nxt;
  logic       w_txload;
  logic [7:0] w_byte;
  logic       w_match;

  always_ff @(posedge clock) begin
    if (Reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], SCL};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], SDAIn};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // SCL must be high on both samples so an SCL edge can never look like START/STOP.
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  assign w_byte = {r_shift[6:0], w_sda};
`ifdef I2C_TARGET_GENCALL_EN
  assign w_match = (w_byte[7:1] == ADDRESS) || (w_byte == 8'h00);
`else
  assign w_match = (w_byte[7:1] == ADDRESS);
`endif

  always_ff @(posedge clock) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= 4'd0;
      r_shift     <= 8'h00;
      r_txshift   <= 8'h00;
      r_rxdata    <= 8'h00;
      r_rw        <= 1'b0;
      r_phase     <= 1'b0;
      r_sda_low   <= 1'b0;
      r_addressed <= 1'b0;
      r_busy      <= 1'b0;
      r_rxvalid   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_shift     <= w_shift_nxt;
      r_txshift   <= w_txshift_nxt;
      r_rxdata    <= w_rxdata_nxt;
      r_rw        <= w_rw_nxt;
      r_phase     <= w_phase_nxt;
      r_sda_low   <= w_sda_low_nxt;
      r_addressed <= w_addressed_nxt;
      r_busy      <= w_busy_nxt;
      r_rxvalid   <= w_rxvalid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_bitcnt_nxt    = r_bitcnt;
    w_shift_nxt     = r_shift;
    w_txshift_nxt   = r_txshift;
    w_rxdata_nxt    = r_rxdata;
    w_rw_nxt        = r_rw;
    w_phase_nxt     = r_phase;
    w_sda_low_nxt   = r_sda_low;
    w_addressed_nxt = r_addressed;
    w_busy_nxt      = r_busy;
    w_rxvalid_nxt   = 1'b0;
    w_txload        = 1'b0;

    if (w_start) begin
      w_state_nxt     = S_ADDR;
      w_bitcnt_nxt    = 4'd0;
      w_busy_nxt      = 1'b1;
      w_addressed_nxt = 1'b0;
      w_sda_low_nxt   = 1'b0;
    end else if (w_stop) begin
      w_state_nxt     = S_IDLE;
      w_busy_nxt      = 1'b0;
      w_addressed_nxt = 1'b0;
      w_sda_low_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt  = w_byte;
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            if (r_bitcnt == c_LAST_BIT) begin
              w_bitcnt_nxt = 4'd0;
              w_phase_nxt  = 1'b0;
              w_rw_nxt     = w_byte[0];
              w_state_nxt  = w_match ? S_ADDR_ACK : S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_phase_nxt     = 1'b1;
              w_sda_low_nxt   = 1'b1;
              w_addressed_nxt = 1'b1;
              if (r_rw) begin
                w_txload      = 1'b1;
                w_txshift_nxt = TxData;
              end
            end else if (r_rw) begin
              // The captured byte's MSB goes out on the same fall that ends the ACK.
              w_sda_low_nxt = ~r_txshift[7];
              w_txshift_nxt = {r_txshift[6:0], 1'b0};
              w_bitcnt_nxt  = 4'd1;
              w_state_nxt   = S_READ;
            end else begin
              w_sda_low_nxt = 1'b0;
              w_bitcnt_nxt  = 4'd0;
              w_state_nxt   = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (w_scl_rise) begin
            w_shift_nxt  = w_byte;
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            if (r_bitcnt == c_LAST_BIT) begin
              w_rxdata_nxt  = w_byte;
              w_rxvalid_nxt = 1'b1;
              w_bitcnt_nxt  = 4'd0;
              w_phase_nxt   = 1'b0;
              w_state_nxt   = S_WRITE_ACK;
            end
          end
        end
        S_WRITE_ACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_phase_nxt   = 1'b1;
              w_sda_low_nxt = 1'b1;
            end else begin
              w_sda_low_nxt = 1'b0;
              w_state_nxt   = S_WRITE;
            end
          end
        end
        S_READ: begin
          if (w_scl_fall) begin
            if (r_bitcnt == c_BYTE_END) begin
              w_sda_low_nxt = 1'b0;
              w_bitcnt_nxt  = 4'd0;
              w_phase_nxt   = 1'b0;
              w_state_nxt   = S_READ_ACK;
            end else begin
              w_sda_low_nxt = ~r_txshift[7];
              w_txshift_nxt = {r_txshift[6:0], 1'b0};
              w_bitcnt_nxt  = r_bitcnt + 4'd1;
            end
          end
        end
        S_READ_ACK: begin
          if (w_scl_rise) begin
            if (w_sda) w_state_nxt = S_IGNORE;
            else       w_phase_nxt = 1'b1;
          end else if (w_scl_fall && r_phase) begin
            w_txload      = 1'b1;
            w_sda_low_nxt = ~TxData[7];
            w_txshift_nxt = {TxData[6:0], 1'b0};
            w_bitcnt_nxt  = 4'd1;
            w_state_nxt   = S_READ;
          end
        end
        S_IGNORE: w_sda_low_nxt = 1'b0;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  // Reset releases the pad combinationally so the bus is freed without waiting an edge.
  assign SDAPullLow = r_sda_low & ~Reset;
  assign TxLoad     = w_txload;
  assign RxData     = r_rxdata;
  assign RxValid    = r_rxvalid;
  assign Addressed  = r_addressed;
  assign Busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target
// Brief    : Bus-controller bench for i2c_target with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_target;

  localparam int QC = 8;

  logic       clk, rst, scl, ctl_sda;
  logic [7:0] tx_data;
  wire        sda_bus;
  logic       pull, txl, rxv, addressed, busy;
  logic [7:0] rxd;

  int   n_cmp = 0, n_err = 0;
  int   act_txload = 0, exp_txload = 0;
  logic exp_busy = 1'b0, exp_addr = 1'b0;
  logic chk_busy = 1'b0, chk_addr = 1'b0, no_pull = 1'b0;
  logic [7:0] rx_q[$];

  assign sda_bus = ctl_sda & ~pull;

  i2c_target #(.ADDRESS(7'h27), .SYNC_STAGES(2)) dut (
    .clock(clk), .Reset(rst), .SCL(scl), .SDAIn(sda_bus), .SDAPullLow(pull),
    .TxData(tx_data), .TxLoad(txl), .RxData(rxd), .RxValid(rxv),
    .Addressed(addressed), .Busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_match(input logic [7:0] b);
`ifdef I2C_TARGET_GENCALL_EN
    return (b[7:1] == 7'h27) || (b == 8'h00);
`else
    return (b[7:1] == 7'h27);
`endif
  endfunction

  always @(negedge clk) begin
    if (rxv) begin
      if (rx_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rx_unexpected: got RxValid with RxData=%0h, expected none", rxd);
      end else check("rxdata", rxd, rx_q.pop_front());
    end
    if (txl) act_txload++;
    if (chk_busy) check("busy", busy, exp_busy);
    if (chk_addr) check("addressed", addressed, exp_addr);
    if (no_pull)  check("no_pull", pull, 1'b0);
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    ctl_sda = b; wclk(QC);
    scl = 1'b1; wclk(QC);
    s = sda_bus; wclk(QC);
    scl = 1'b0; wclk(QC);
  endtask

  task automatic bus_start();
    chk_addr = 1'b0;
    if (!exp_busy) chk_busy = 1'b0;
    ctl_sda = 1'b1; wclk(QC);
    scl = 1'b1;     wclk(QC);
    ctl_sda = 1'b0; wclk(QC);
    scl = 1'b0;     wclk(QC);
    exp_busy = 1'b1; exp_addr = 1'b0; chk_busy = 1'b1; chk_addr = 1'b1;
  endtask

  task automatic bus_stop();
    chk_busy = 1'b0; chk_addr = 1'b0;
    ctl_sda = 1'b0; wclk(QC);
    scl = 1'b1;     wclk(QC);
    ctl_sda = 1'b1; wclk(QC);
    exp_busy = 1'b0; exp_addr = 1'b0; chk_busy = 1'b1; chk_addr = 1'b1;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    logic [7:0] seen;
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(b[i], s);
      seen[i] = s;
    end
    check({nm, "_bits"}, seen, b);
    clk_bit(1'b1, s);
    check({nm, "_ack"}, s, exp_ack ? 1'b0 : 1'b1);
  endtask

  task automatic addr_byte(input logic [7:0] b);
    logic m;
    m = model_match(b);
    chk_addr = 1'b0;
    if (m && b[0]) exp_txload++;
    write_byte(b, m, "addr");
    exp_addr = m; chk_addr = 1'b1;
  endtask

  task automatic wdata(input logic [7:0] b);
    if (exp_addr) rx_q.push_back(b);
    write_byte(b, exp_addr, "wdata");
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic ack, input logic [7:0] nxt);
    logic [7:0] seen;
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      seen[i] = s;
    end
    check("rdata", seen, exp);
    tx_data = nxt;
    if (ack) exp_txload++;
    clk_bit(ack ? 1'b0 : 1'b1, s);
    check("rd_ackslot", s, ack ? 1'b0 : 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic s;
    rst = 1'b1; scl = 1'b1; ctl_sda = 1'b1; tx_data = 8'h00;
    wclk(5);
    check("rst_pull", pull, 1'b0);
    check("rst_txload", txl, 1'b0);
    check("rst_rxvalid", rxv, 1'b0);
    check("rst_rxdata", rxd, 8'h00);
    check("rst_addressed", addressed, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    wclk(5);
    chk_busy = 1'b1; chk_addr = 1'b1;

    // Write 0xA5 to 0x27
    bus_start(); addr_byte(8'h4E); wdata(8'hA5); bus_stop();
    wclk(4);
    check("wr_rxdata_lit", rxd, 8'hA5);
    check("wr_rx_drained", rx_q.size(), 0);

    // Single-byte read of 0x3C, controller NACK
    tx_data = 8'h3C;
    bus_start(); addr_byte(8'h4F); read_byte(8'h3C, 1'b0, 8'h00); bus_stop();
    wclk(4);
    check("rd_txload_cnt", act_txload, exp_txload);
    check("rd_txload_lit", act_txload, 1);

    // Two-byte read
    tx_data = 8'h81;
    bus_start(); addr_byte(8'h4F); read_byte(8'h81, 1'b1, 8'h7E);
    read_byte(8'h7E, 1'b0, 8'h00); bus_stop();
    wclk(4);
    check("rd2_txload_cnt", act_txload, exp_txload);
    check("rd2_txload_lit", act_txload, 3);

    // Address mismatch: target must stay silent
    no_pull = 1'b1;
    bus_start(); addr_byte(8'h50); wdata(8'h12); bus_stop();
    no_pull = 1'b0;
    check("mm_rxdata_hold", rxd, 8'hA5);

    // General-call address byte
`ifndef I2C_TARGET_GENCALL_EN
    no_pull = 1'b1;
`endif
    bus_start(); addr_byte(8'h00); wdata(8'h66); bus_stop();
    no_pull = 1'b0;
    wclk(4);

    // Write then repeated START into a read
    bus_start(); addr_byte(8'h4E); wdata(8'h11);
    tx_data = 8'hC3;
    bus_start(); addr_byte(8'h4F); read_byte(8'hC3, 1'b0, 8'h00); bus_stop();
    wclk(4);
    check("rs_rxdata_lit", rxd, 8'h11);
    check("rs_txload_cnt", act_txload, exp_txload);

    // Reset in the middle of a read while the target drives bit 3
    tx_data = 8'h00;
    bus_start(); addr_byte(8'h4F);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
    check("pre_rst_pull", pull, 1'b1);
    chk_busy = 1'b0; chk_addr = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_pull", pull, 1'b0);
    check("mid_rst_txload", txl, 1'b0);
    check("mid_rst_rxvalid", rxv, 1'b0);
    check("mid_rst_rxdata", rxd, 8'h00);
    check("mid_rst_addressed", addressed, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    wclk(2);
    rst = 1'b0;
    exp_busy = 1'b0; exp_addr = 1'b0; rx_q.delete();
    wclk(4);
    chk_busy = 1'b1; chk_addr = 1'b1;
    bus_start(); addr_byte(8'h4E); wdata(8'h5A); bus_stop();
    wclk(4);
    check("post_rst_rxdata", rxd, 8'h5A);

    check("end_rx_drained", rx_q.size(), 0);
    check("end_txload_cnt", act_txload, exp_txload);
    wclk(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- 7-bit-address I2C target (responder); the bus-side counterpart of the team's I2C_Controller.
- Oversamples SCL/SDA on the system clock and detects START, STOP and repeated START.
- Matches its address, ACKs, delivers written bytes to local logic and shifts local data out on reads.
- Open-drain SDA: drives low only, never high. No clock stretching.

Parameters:
- ADDRESS, 7'h27, target address matched against the first 7 bits after START.
- SYNC_STAGES, 2, synchronizer depth on SCL and SDAIn; legal values 2..3.

Ports:
- clock  input  1  system clock; SCL low and high phases are each at least 4 clock periods plus SYNC_STAGES.
- Reset  input  1  synchronous, active-high reset.
- SCL  input  1  bus clock as seen at the pad.
- SDAIn  input  1  bus data as seen at the pad.
- SDAPullLow  output  1  1 = pad pulls SDA low; 0 = released.
- TxData  input  8  byte to send on the next read byte; sampled when TxLoad = 1.
- TxLoad  output  1  one-clock pulse; TxData captured this cycle.
- RxData  output  8  last byte written by the controller; holds until the next write byte.
- RxValid  output  1  one-clock pulse; RxData updated.
- Addressed  output  1  high from the address ACK until STOP, repeated START or Reset.
- Busy  output  1  high between START and STOP.

Behaviour:
- Reset: all synchronizer flops = 1, SDAPullLow = 0, TxLoad = 0, RxValid = 0, RxData = 8'h00, Addressed = 0, Busy = 0, state = Idle.
- Reset mid-transfer: same result on the next clock edge; SDA is released immediately.
- Edge detection is done only on the synchronized signals: SCLrise, SCLfall, START (SDA 1→0 while SCL = 1), STOP (SDA 0→1 while SCL = 1).
- START and STOP take priority over all states.
  - START in any state: go to Address, clear the bit counter, Busy = 1, Addressed = 0, SDAPullLow = 0.
  - STOP in any state: go to Idle, Busy = 0, Addressed = 0, SDAPullLow = 0.
- Bits are sampled on SCLrise. SDAPullLow changes only on SCLfall, except for release on START/STOP/Reset.
- Bit counter: 4 bits, counts 0..8. Bytes are MSB first.
- States:
  - Idle: wait for START.
  - Address: shift 8 bits. On the 8th SCLrise, compare bits[7:1] with ADDRESS.
    - Match: go to AddrAck and latch the R/W bit.
    - Mismatch: go to Ignore.
  - AddrAck: on the next SCLfall, SDAPullLow = 1 and Addressed = 1.
    - If R/W = 1, TxLoad pulses in that same cycle.
    - On the following SCLfall, release SDA and enter Write (R/W = 0) or Read (R/W = 1).
    - When entering Read, drive TxData[7] in the same cycle (SDAPullLow = ~bit).
  - Write: shift 8 bits. On the 8th SCLrise, RxData = shifted byte, RxValid pulses the next clock, go to WriteAck.
  - WriteAck: pull SDA low from the next SCLfall to the following SCLfall, then release and return to Write.
  - Read: each SCLfall presents the next bit. After the 8th bit's SCLfall, release SDA and go to ReadAck.
  - ReadAck: sample SDA on SCLrise.
    - 0 (ACK): on the next SCLfall, pulse TxLoad and present the new bit 7; go to Read.
    - 1 (NACK): go to Ignore.
  - Ignore: SDA released; wait for START or STOP.
- The data phase has no byte limit.
- Glitch-free: SDA changes while SCL = 1 outside START/STOP never alter shift data.

Optional Feature:
- Macro: I2C_TARGET_GENCALL_EN.
- Defined: address byte 8'h00 (general call, write) is also ACKed.
  - Following bytes are delivered via RxData/RxValid like a normal write.
  - Addressed = 1 during the transfer.
  - Address byte 8'h01 goes to Ignore.
- Undefined: 8'h00 is treated as a mismatch → Ignore, no ACK.

Test Plan:
- Write: START, 8'h4E, 8'hA5, STOP → address ACK low; RxData = 8'hA5 with exactly one RxValid pulse; data ACK low; Busy drops after STOP; Addressed = 0.
- Read: START, 8'h4F, TxData = 8'h3C, controller NACK, STOP → SDA bits 0,0,1,1,1,1,0,0; TxLoad pulses exactly once; SDA released during the ACK slot; Idle.
- Two-byte read: TxData = 8'h81 then 8'h7E, controller ACK then NACK → bytes 8'h81, 8'h7E observed; two TxLoad pulses.
- Mismatch: START, 8'h50, 8'h12, STOP → SDAPullLow stays 0 throughout; no RxValid; Addressed = 0.
- Repeated START: write 8'h4E/8'h11, then START, 8'h4F, read 8'hC3 → RxValid for 8'h11; read byte 8'hC3 correct; Busy stays 1 across the repeated START.
- Reset mid-read: Reset = 1 while driving bit 3 → next clock SDAPullLow = 0 and all outputs at reset values; a subsequent write of 8'h5A is ACKed and received correctly.
